// File: rtl/sgdmac_burst_splitter.sv
// Splits one {start_addr, byte_len} DMA command into AXI bursts of at most
// MAX_BEATS 32-bit beats that never cross a BOUNDARY-byte address boundary.
module sgdmac_burst_splitter #(
  parameter int MAX_BEATS = 16,
  parameter int BOUNDARY  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [47:0] cmd_i,
  output logic        burst_valid_o,
  input  logic        burst_ready_i,
  output logic [31:0] burst_addr_o,
  output logic [3:0]  burst_len_o,
  output logic        burst_last_o,
  output logic        idle_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [32:0] BND      = 33'(BOUNDARY);
  localparam logic [31:0] BND_MASK = 32'(BOUNDARY - 1);

  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [13:0] rem_words_q, rem_words_d;

  logic [4:0]  beats;
  logic [32:0] room_words;
  logic        last;
  logic        cmd_fire;
  logic        burst_fire;
  logic        unused_cmd_bits;

  // Address and length bits below word granularity carry no information.
  assign unused_cmd_bits = ^{cmd_i[17:16], cmd_i[1:0]};

  always_comb begin
    room_words = (BND - {1'b0, cur_addr_q & BND_MASK}) >> 2;
    beats      = 5'(MAX_BEATS);
    if (rem_words_q < 14'(MAX_BEATS)) beats = rem_words_q[4:0];
    if (room_words < 33'(beats))      beats = 5'(room_words);
  end

  assign last       = (14'(beats) == rem_words_q);
  assign cmd_fire   = cmd_valid_i && (state_q == IDLE);
  assign burst_fire = burst_ready_i && (state_q == BURST);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_words_d = rem_words_q;
    if (cmd_fire) begin
      cur_addr_d  = {cmd_i[47:18], 2'b00};
      rem_words_d = cmd_i[15:2];
      state_d     = (cmd_i[15:2] != 14'd0) ? BURST : IDLE;
    end else if (burst_fire) begin
      cur_addr_d  = cur_addr_q + (32'(beats) << 2);
      rem_words_d = rem_words_q - 14'(beats);
      state_d     = last ? IDLE : BURST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= 32'd0;
      rem_words_q <= 14'd0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_words_q <= rem_words_d;
    end
  end

  // Outputs decode directly from registered state; len/last are gated so the
  // idle view (rem_words may be 0) never shows a wrapped beats-1.
  assign cmd_ready_o   = (state_q == IDLE);
  assign idle_o        = (state_q == IDLE);
  assign burst_valid_o = (state_q == BURST);
  assign burst_addr_o  = cur_addr_q;
  assign burst_len_o   = burst_valid_o ? 4'(beats - 5'd1) : 4'd0;
  assign burst_last_o  = burst_valid_o && last;

endmodule

// File: tb/tb_sgdmac_burst_splitter.sv
// Directed plus randomized bench for sgdmac_burst_splitter against a
// burst-list reference model built from the splitting rules.
module tb_sgdmac_burst_splitter;

  localparam int MAX_BEATS = 16;
  localparam int BOUNDARY  = 4096;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [47:0] cmd_i;
  logic        burst_valid_o;
  logic        burst_ready_i;
  logic [31:0] burst_addr_o;
  logic [3:0]  burst_len_o;
  logic        burst_last_o;
  logic        idle_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic        last;
  } burst_t;

  burst_t exp_q[$];

  sgdmac_burst_splitter #(.MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_i        (cmd_i),
    .burst_valid_o(burst_valid_o),
    .burst_ready_i(burst_ready_i),
    .burst_addr_o (burst_addr_o),
    .burst_len_o  (burst_len_o),
    .burst_last_o (burst_last_o),
    .idle_o       (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the word range, cutting at MAX_BEATS, remaining length
  // and the next BOUNDARY multiple.
  task automatic build_model(input logic [31:0] addr, input logic [15:0] len);
    longint unsigned a;
    int w, room, b;
    burst_t e;
    exp_q.delete();
    a = longint'(addr) & 64'hFFFF_FFFC;
    w = int'(len) / 4;
    while (w > 0) begin
      room = (BOUNDARY - int'(a % BOUNDARY)) / 4;
      b = MAX_BEATS;
      if (w < b) b = w;
      if (room < b) b = room;
      e.addr = a[31:0];
      e.len  = 4'(b - 1);
      e.last = (b == w);
      exp_q.push_back(e);
      a = (a + 4 * b) % 64'h1_0000_0000;
      w -= b;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
    chk({tag, "_idle"},  64'(idle_o), 64'd1);
    chk({tag, "_valid"}, 64'(burst_valid_o), 64'd0);
  endtask

  // Issue one command and consume every burst. rdy_pct sets the random
  // burst_ready_i density; hold forces ready low on the first burst.
  task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len,
                          input int rdy_pct, input int hold);
    int waitc;
    bit done;
    build_model(addr, len);
    chk("pre_cmd_ready", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_i = {addr, len};
    step();
    cmd_valid_i = 1'b0;
    cmd_i = {$urandom, 16'($urandom)};
    if (exp_q.size() == 0) begin
      check_idle("zero");
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      done = 1'b0;
      waitc = 0;
      while (!done) begin
        chk("b_valid", 64'(burst_valid_o), 64'd1);
        chk("b_idle",  64'(idle_o), 64'd0);
        chk("b_addr",  64'(burst_addr_o), 64'(exp_q[i].addr));
        chk("b_len",   64'(burst_len_o), 64'(exp_q[i].len));
        chk("b_last",  64'(burst_last_o), 64'(exp_q[i].last));
        burst_ready_i = ($urandom_range(99) < rdy_pct);
        if (i == 0 && waitc < hold) burst_ready_i = 1'b0;
        if (waitc > 20) burst_ready_i = 1'b1;
        done = burst_ready_i;
        step();
        waitc++;
      end
    end
    burst_ready_i = 1'b0;
    check_idle("post");
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i = '0;
    burst_ready_i = 1'b0;
    step();
    step();
    check_idle("rst");
    chk("rst_addr", 64'(burst_addr_o), 64'd0);
    chk("rst_len",  64'(burst_len_o), 64'd0);
    chk("rst_last", 64'(burst_last_o), 64'd0);
    rst_n = 1'b1;
    step();
    check_idle("rst_rel");

    // Aligned, boundary crossing, short unaligned, zero length
    send_cmd(32'h0000_1000, 16'd256, 100, 0);
    send_cmd(32'h0000_1FF0, 16'd64, 100, 0);
    send_cmd(32'h0000_0103, 16'd11, 100, 0);
    send_cmd(32'h0000_4000, 16'd3, 100, 0);

    // Back-to-back zero-length commands, one per cycle
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_i = {$urandom, 16'($urandom_range(3))};
      step();
      check_idle("zero_b2b");
    end
    cmd_valid_i = 1'b0;

    // Backpressure: first burst held for 5 cycles
    send_cmd(32'h0000_0000, 16'd128, 100, 5);

    // Reset mid-command after first burst, at the top of the address space
    build_model(32'hFFFF_FFC0, 16'd128);
    cmd_valid_i = 1'b1;
    cmd_i = {32'hFFFF_FFC0, 16'd128};
    step();
    cmd_valid_i = 1'b0;
    chk("wrap_b0_addr", 64'(burst_addr_o), 64'(exp_q[0].addr));
    chk("wrap_b0_len",  64'(burst_len_o), 64'(exp_q[0].len));
    burst_ready_i = 1'b1;
    step();
    burst_ready_i = 1'b0;
    chk("wrap_b1_addr", 64'(burst_addr_o), 64'(exp_q[1].addr));
    chk("wrap_b1_valid", 64'(burst_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_addr", 64'(burst_addr_o), 64'd0);
    chk("async_rst_len",  64'(burst_len_o), 64'd0);
    chk("async_rst_last", 64'(burst_last_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    send_cmd(32'hFFFF_FFF8, 16'd16, 100, 0);

    // Randomized commands with random backpressure
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [15:0] l;
      a = $urandom;
      if ($urandom_range(3) == 0) a = 32'hFFFF_F000 | 32'($urandom_range(4095));
      if ($urandom_range(3) == 0) a[11:0] = 12'hFC0 | 12'($urandom_range(63));
      l = 16'($urandom_range(600));
      if ($urandom_range(7) == 0) l = 16'($urandom_range(3));
      send_cmd(a, l, 30 + int'($urandom_range(70)), int'($urandom_range(2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
